// File: rtl/hex_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : hex_keypad_scanner
//  Purpose  : Column-by-column scanner and debouncer for a 4x4 hex keypad.
//             Each accepted press yields a nibble. Nibble pairs are packed
//             high-first into a byte and offered on a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          in   1  system clock, rising edge
//    reset_n_i      in   1  synchronous active-low reset
//    row_in_i       in   4  keypad rows, active-low, asynchronous
//    col_out_o      out  4  column drive, exactly one bit low
//    key_code_o     out  4  last accepted key value
//    key_valid_o    out  1  one-cycle pulse when key_code_o updates
//    byte_data_o    out  8  {first nibble, second nibble}
//    byte_valid_o   out  1  byte_data_o valid, held until accepted
//    byte_ready_i   in   1  consumer ready
//    nibble_sel_o   out  1  0: next key fills [7:4], 1: next key fills [3:0]
//    overrun_o      out  1  sticky, a key was dropped while a byte was pending
// ============================================================================
module hex_keypad_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [3:0] row_in_i,
  output logic [3:0] col_out_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       nibble_sel_o,
  output logic       overrun_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DB_PRESS = 2'd1,
    S_HELD     = 2'd2,
    S_DB_REL   = 2'd3
  } state_t;

  // Row/column intersection to key value.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [1:0]       hit_cnt_q;
  logic [3:0]       hit_code_q;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             nibble_sel_q;
  logic             overrun_q;

  // --------------------------------------------------------------------------
  // Per-column sample decode
  // --------------------------------------------------------------------------
  logic [3:0] hits;
  logic [2:0] col_cnt;
  logic [1:0] col_row;
  logic [3:0] col_code;
  logic       sample;
  logic       scan_end;
  logic [2:0] base_cnt;
  logic [2:0] tot_cnt;
  logic [1:0] tot_sat;
  logic [3:0] tot_code;
  logic       scan_none, scan_key, scan_multi;
  logic       accept;
  logic       handshake;

  assign hits    = ~row_sync_q;
  assign col_cnt = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);

  // Row index of the lowest pressed row; only meaningful when exactly one hit.
  always_comb begin
    col_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i]) col_row = 2'(i);
    end
  end

  assign col_code = key_map(col_row, col_q);
  assign sample   = (div_q == DIV_LAST);
  assign scan_end = sample && (col_q == 2'd3);

  // Column 0 starts a fresh scan, so the running count is ignored there.
  // Counts saturate at 2 since only none/one/many matters.
  assign base_cnt = (col_q == 2'd0) ? 3'd0 : {1'b0, hit_cnt_q};
  assign tot_cnt  = base_cnt + col_cnt;
  assign tot_sat  = (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
  assign tot_code = (base_cnt == 3'd1) ? hit_code_q : col_code;

  assign scan_none  = (tot_sat == 2'd0);
  assign scan_key   = (tot_sat == 2'd1);
  assign scan_multi = (tot_sat == 2'd2);

  assign handshake = byte_valid_q & byte_ready_i;

  // --------------------------------------------------------------------------
  // Debounce FSM, evaluated on the last sample of each full scan
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (scan_end && !scan_multi) begin
      case (state_q)
        S_IDLE: begin
          if (scan_key) begin
            cand_d = tot_code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE == 1) begin
              state_d = S_HELD;
              accept  = 1'b1;
            end else begin
              state_d = S_DB_PRESS;
            end
          end
        end
        S_DB_PRESS: begin
          if (scan_none) begin
            state_d = S_IDLE;
          end else if (tot_code == cand_q) begin
            cnt_d = cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == DB_TARGET) begin
              state_d = S_HELD;
              accept  = 1'b1;
            end
          end else begin
            cand_d = tot_code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE == 1) begin
              state_d = S_HELD;
              accept  = 1'b1;
            end
          end
        end
        S_HELD: begin
          if (scan_none) begin
            cnt_d   = CNT_ONE;
            state_d = (DEBOUNCE == 1) ? S_IDLE : S_DB_REL;
          end
        end
        S_DB_REL: begin
          if (scan_none) begin
            cnt_d = cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == DB_TARGET) state_d = S_IDLE;
          end else begin
            state_d = S_HELD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      div_q        <= '0;
      col_q        <= 2'd0;
      hit_cnt_q    <= 2'd0;
      hit_code_q   <= 4'h0;
      state_q      <= S_IDLE;
      cand_q       <= 4'h0;
      cnt_q        <= '0;
      key_code_q   <= 4'h0;
      key_valid_q  <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      nibble_sel_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      row_meta_q <= row_in_i;
      row_sync_q <= row_meta_q;

      if (sample) begin
        div_q      <= '0;
        col_q      <= col_q + 2'd1;
        hit_cnt_q  <= tot_sat;
        hit_code_q <= tot_code;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= cand_d;

      // A handshake this cycle frees the byte for the incoming key.
      if (handshake) byte_valid_q <= 1'b0;
      if (key_valid_q) begin
        if (byte_valid_q && !handshake) begin
          overrun_q <= 1'b1;
        end else if (!nibble_sel_q) begin
          byte_data_q[7:4] <= key_code_q;
          nibble_sel_q     <= 1'b1;
        end else begin
          byte_data_q[3:0] <= key_code_q;
          byte_valid_q     <= 1'b1;
          nibble_sel_q     <= 1'b0;
        end
      end
    end
  end

  assign col_out_o    = ~(4'b0001 << col_q);
  assign key_code_o   = key_code_q;
  assign key_valid_o  = key_valid_q;
  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign nibble_sel_o = nibble_sel_q;
  assign overrun_o    = overrun_q;

endmodule
`default_nettype wire
